// File: rtl/sdram_arbiter.sv
// Two-port req/ack arbiter in front of the SDRAM controller; also owns the auto-refresh schedule.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; the default build uses fixed port-0 priority.
module sdram_arbiter #(
    parameter int unsigned REF_INTERVAL = 810,
    parameter int unsigned REF_OWED_MAX = 7
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [22:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_be,
    output logic [31:0] p0_rdata,
    output logic        p0_ack,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [22:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_be,
    output logic [31:0] p1_rdata,
    output logic        p1_ack,

    output logic        sd_rd,
    output logic        sd_wr,
    output logic        sd_refresh,
    output logic [22:0] sd_addr,
    output logic [31:0] sd_din,
    output logic [3:0]  sd_mask,
    input  logic [31:0] sd_dout,
    input  logic        sd_data_ready,
    input  logic        sd_busy
);

    localparam int unsigned TimerW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(REF_INTERVAL - 1);
    localparam logic [2:0] OwedMax = 3'(REF_OWED_MAX);

    typedef enum logic [1:0] {StIdle, StWaitAcc, StWaitDone, StResp} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        owed_q, owed_d;
    logic              grant_q, grant_d;   // port of the op in flight
    logic              op_ref_q, op_ref_d;
    logic              op_we_q, op_we_d;
    logic              wrap, ref_issue, pick;

    logic        sd_rd_d, sd_wr_d, sd_refresh_d;
    logic [22:0] sd_addr_d;
    logic [31:0] sd_din_d;
    logic [3:0]  sd_mask_d;
    logic [31:0] p0_rdata_d, p1_rdata_d;
    logic        p0_ack_d, p1_ack_d;

`ifdef SDRAM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        pick = p1_req;
        if (p0_req && p1_req) begin
            pick = ~last_grant_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign pick = ~p0_req;
`endif

    assign wrap = (timer_q == TimerLast);

    always_comb begin
        state_d      = state_q;
        timer_d      = wrap ? '0 : timer_q + 1'b1;
        owed_d       = owed_q;
        grant_d      = grant_q;
        op_ref_d     = op_ref_q;
        op_we_d      = op_we_q;
        ref_issue    = 1'b0;
        sd_rd_d      = 1'b0;
        sd_wr_d      = 1'b0;
        sd_refresh_d = 1'b0;
        sd_addr_d    = sd_addr;
        sd_din_d     = sd_din;
        sd_mask_d    = sd_mask;
        p0_rdata_d   = p0_rdata;
        p1_rdata_d   = p1_rdata;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
`ifdef SDRAM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (!sd_busy) begin
                    if (owed_q != 3'd0) begin
                        ref_issue    = 1'b1;
                        sd_refresh_d = 1'b1;
                        op_ref_d     = 1'b1;
                        state_d      = StWaitAcc;
                    end else if (p0_req || p1_req) begin
                        op_ref_d  = 1'b0;
                        grant_d   = pick;
                        op_we_d   = pick ? p1_we : p0_we;
                        sd_addr_d = pick ? p1_addr : p0_addr;
                        sd_din_d  = pick ? p1_wdata : p0_wdata;
                        sd_mask_d = pick ? ~p1_be : ~p0_be;
                        sd_rd_d   = pick ? ~p1_we : ~p0_we;
                        sd_wr_d   = pick ? p1_we : p0_we;
                        state_d   = StWaitAcc;
`ifdef SDRAM_ARB_RR_EN
                        last_grant_d = pick;
`endif
                    end
                end
            end
            StWaitAcc: begin
                if (sd_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (sd_data_ready && !op_ref_q && !op_we_q) begin
                    if (grant_q) begin
                        p1_rdata_d = sd_dout;
                    end else begin
                        p0_rdata_d = sd_dout;
                    end
                end
                if (!sd_busy) begin
                    if (op_ref_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StResp;
                        p0_ack_d = ~grant_q;
                        p1_ack_d = grant_q;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A credit arriving in the same cycle a refresh issues cancels out.
        if (wrap && !ref_issue) begin
            owed_d = (owed_q == OwedMax) ? owed_q : owed_q + 3'd1;
        end else if (!wrap && ref_issue) begin
            owed_d = owed_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            owed_q     <= 3'd0;
            grant_q    <= 1'b0;
            op_ref_q   <= 1'b0;
            op_we_q    <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_refresh <= 1'b0;
            sd_addr    <= '0;
            sd_din     <= '0;
            sd_mask    <= 4'hF;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            owed_q     <= owed_d;
            grant_q    <= grant_d;
            op_ref_q   <= op_ref_d;
            op_we_q    <= op_we_d;
            sd_rd      <= sd_rd_d;
            sd_wr      <= sd_wr_d;
            sd_refresh <= sd_refresh_d;
            sd_addr    <= sd_addr_d;
            sd_din     <= sd_din_d;
            sd_mask    <= sd_mask_d;
            p0_rdata   <= p0_rdata_d;
            p1_rdata   <= p1_rdata_d;
            p0_ack     <= p0_ack_d;
            p1_ack     <= p1_ack_d;
        end
    end

endmodule
